can_encoder: RTL and testbench
==============================

// Module: can_encoder
// PURPOSE
//  Transmit side of the CAN link; its serial output feeds can_decoder's rx_bit.
//  Latches one frame (standard or extended) from field_* inputs on tx_start.
//  Serialises the frame onto tx_bit: CRC-15 generation, bit stuffing, ACK
//  check, EOF and intermission. Bit timing comes from the shared sample_point.
// PARAMETERS
//  STUFF_LEN   5  equal consecutive bits that force a complement stuff bit
//  IFS_BITS    3  recessive intermission bits after EOF before returning to IDLE
//  EOF_BITS    7  recessive end-of-frame bits
// PORTS
//  clock         in   1   system clock, all logic on posedge
//  reset         in   1   synchronous, active-high
//  sample_point  in   1   bit-timing strobe shared with can_decoder
//  rx_bit        in   1   bus readback, sampled only in the ACK slot
//  tx_start      in   1   request to send; honoured only in IDLE
//  field_id_a    in   11  base identifier, MSB first
//  field_ide     in   1   0 = standard frame, 1 = extended frame
//  field_rtr     in   1   remote frame; no data field sent
//  field_id_b    in   18  extension identifier; used when ide=1
//  field_dlc     in   4   data length code, sent as given
//  field_data    in   64  byte0 = [63:56], sent MSB first
//  tx_bit        out  1   serial output; 1 = recessive
//  tx_busy       out  1   high from accepted tx_start until return to IDLE
//  tx_done       out  1   1-clock pulse on return to IDLE after a full frame
//  ack_error     out  1   1-clock pulse when the ACK slot reads recessive
//  field_crc     out  15  CRC of the current frame, valid from the CRC state onward
// BEHAVIOUR
//  Reset: state=IDLE, tx_bit=1, tx_busy=0, tx_done=0, ack_error=0, field_crc=0.
//    Reset mid-frame aborts the frame; tx_bit=1 on the next clock; no tx_done.
//  Edges: drive_tick = falling edge of sample_point, detected against a registered copy.
//    sample_tick = rising edge of sample_point, detected the same way.
//  tx_bit changes exactly 1 clock after drive_tick; can_decoder samples it on sample_tick.
//  tx_start in IDLE: latch all field_* inputs; clear the CRC and stuff counter; tx_busy=1.
//    The SOF bit drives on the next drive_tick. tx_start while busy is ignored.
//  States, one bit per drive_tick:
//    IDLE -> SOF(0) -> ID_A(11) -> [ide=0: RTR, IDE, R0] or
//    [ide=1: SRR=1, IDE=1, ID_B(18), RTR, R1=0, R0=0] -> DLC(4) -> DATA
//    -> CRC(15) -> CRC_DELIM(1) -> ACK_SLOT(1) -> ACK_DELIM(1) -> EOF -> IFS -> IDLE.
//  Standard frame: IDE=0, R0=0. Reserved bits are always sent dominant.
//  DATA length: 8*min(dlc,8) bits. Zero bits when rtr=1 or dlc=0; DATA is then skipped.
//  CRC-15: polynomial 0x4599, init 0. Covers unstuffed bits SOF through the last DATA bit.
//    Per bit: nxt = bit ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? 15'h4599 : 0).
//  Stuffing covers SOF..last CRC bit. After STUFF_LEN equal consecutive sent bits
//    (stuff bits included), the next drive_tick sends the complement.
//  A stuff bit does not advance the state or the CRC. It restarts the run at count 1.
//  No stuffing from CRC_DELIM onward. CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF, IFS are all 1.
//  ACK: on the sample_tick inside ACK_SLOT, rx_bit=1 -> ack_error pulse.
//    The frame still completes.
//  IDLE: tx_done pulses 1 clock on entry from IFS; tx_busy falls in the same clock.
//  tx_bit stays 1 in IDLE.
//  Unstuffed bits SOF..EOF: standard 44+8n, extended 64+8n, where n = data bytes sent.
//  Stuff bits are added on top of these counts.
// TESTING
//  T1: std, id_a=0, rtr=0, dlc=0 -> tx_bit starts 0,0,0,0,0,1,0,0,0,0,0,1.
//      Then 44 unstuffed bits total, then 3 IFS bits, then tx_done.
//  T2: std, id_a=11'h123, dlc=1, data[63:56]=8'hAA, rx_bit=0 in ACK slot
//      -> field_crc matches a reference CRC-15 model.
//      -> can_decoder recovers id_a=0x123, dlc=1, data byte 0xAA; no ack_error.
//  T3: ext, id_a=11'h7FF, id_b=18'h3FFFF, dlc=8, data=64'hFF.. -> stuff 0 after every 5 ones.
//      -> decoder recovers every field; 128 unstuffed bits plus stuff bits.
//  T4: rtr=1, dlc=4 -> DLC field sent as 0100; no DATA bits.
//      -> CRC starts right after the DLC field.
//  T5: rx_bit held 1 through ACK slot -> ack_error pulses once; tx_done still pulses.
//  T6: reset asserted mid ID_A -> tx_bit=1 and tx_busy=0 next clock.
//      -> no tx_done; a new tx_start sends a clean frame.

Source files
------------

// File: rtl/can_encoder.sv
// can_encoder: CAN transmit serialiser. Latches one standard or extended
// frame on tx_start and shifts it out on tx_bit, one bit per falling edge of
// sample_point. It adds the CRC-15, bit stuffing, the ACK check, EOF and
// intermission.
module can_encoder #(
    parameter int unsigned STUFF_LEN = 5,
    parameter int unsigned IFS_BITS  = 3,
    parameter int unsigned EOF_BITS  = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_point,
    input  logic        rx_bit,
    input  logic        tx_start,
    input  logic [10:0] field_id_a,
    input  logic        field_ide,
    input  logic        field_rtr,
    input  logic [17:0] field_id_b,
    input  logic [3:0]  field_dlc,
    input  logic [63:0] field_data,
    output logic        tx_bit,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        ack_error,
    output logic [14:0] field_crc
);

    // r_state names the field of the bit currently on tx_bit; S_START waits
    // for the first drive tick after an accepted tx_start.
    typedef enum logic [4:0] {
        S_IDLE, S_START, S_SOF, S_ID_A, S_SRR, S_IDE, S_ID_B, S_RTR, S_R1,
        S_R0, S_DLC, S_DATA, S_CRC, S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM,
        S_EOF, S_IFS
    } state_t;

    localparam logic [3:0] LP_STUFF    = 4'(STUFF_LEN);
    localparam logic [5:0] LP_EOF_LAST = 6'(EOF_BITS - 1);
    localparam logic [5:0] LP_IFS_LAST = 6'(IFS_BITS - 1);

    state_t      r_state;
    state_t      w_nxt_state;
    logic [5:0]  r_cnt;
    logic [5:0]  w_nxt_cnt;
    logic        w_done;

    logic        r_sp_q;
    logic        r_tx_bit;
    logic        r_done;
    logic        r_ack_err;
    logic [14:0] r_crc;
    logic [3:0]  r_run;

    logic [10:0] r_id_a;
    logic        r_ide;
    logic        r_rtr;
    logic [17:0] r_id_b;
    logic [3:0]  r_dlc;
    logic [63:0] r_data;

    logic        w_drive_tick;
    logic        w_sample_tick;
    logic [6:0]  w_len_bits;
    logic [5:0]  w_data_last;
    logic        w_in_stuff;
    logic        w_stuff;
    logic        w_field_bit;
    logic        w_crc_fb;
    logic [14:0] w_crc_next;

    assign w_drive_tick  = r_sp_q & ~sample_point;
    assign w_sample_tick = ~r_sp_q & sample_point;

    // Data field length in bits: 8*min(dlc,8), none for a remote frame.
    assign w_len_bits  = r_rtr ? 7'd0 :
                         (r_dlc[3] ? 7'd64 : {1'b0, r_dlc[2:0], 3'b000});
    assign w_data_last = w_len_bits[5:0] - 6'd1;

    // The run counter includes the bit just sent (r_tx_bit) and stuff bits.
    assign w_in_stuff = (r_state >= S_SOF) && (r_state <= S_CRC);
    assign w_stuff    = w_in_stuff && (r_run == LP_STUFF);

    assign w_crc_fb   = w_field_bit ^ r_crc[14];
    assign w_crc_next = {r_crc[13:0], 1'b0} ^ (w_crc_fb ? 15'h4599 : 15'h0000);

    assign tx_bit    = r_tx_bit;
    assign tx_busy   = (r_state != S_IDLE);
    assign tx_done   = r_done;
    assign ack_error = r_ack_err;
    assign field_crc = r_crc;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Next field/bit index; a stuff bit holds the current position.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_done      = 1'b0;
        if (r_state == S_IDLE) begin
            if (tx_start) begin
                w_nxt_state = S_START;
                w_nxt_cnt   = '0;
            end
        end else if (w_drive_tick && !w_stuff) begin
            w_nxt_cnt = r_cnt + 6'd1;
            case (r_state)
                S_START:     begin w_nxt_state = S_SOF;  w_nxt_cnt = '0; end
                S_SOF:       begin w_nxt_state = S_ID_A; w_nxt_cnt = '0; end
                S_ID_A: begin
                    if (r_cnt == 6'd10) begin
                        w_nxt_state = r_ide ? S_SRR : S_RTR;
                        w_nxt_cnt   = '0;
                    end
                end
                S_SRR:       begin w_nxt_state = S_IDE;  w_nxt_cnt = '0; end
                S_IDE: begin
                    w_nxt_state = r_ide ? S_ID_B : S_R0;
                    w_nxt_cnt   = '0;
                end
                S_ID_B: begin
                    if (r_cnt == 6'd17) begin
                        w_nxt_state = S_RTR;
                        w_nxt_cnt   = '0;
                    end
                end
                S_RTR: begin
                    w_nxt_state = r_ide ? S_R1 : S_IDE;
                    w_nxt_cnt   = '0;
                end
                S_R1:        begin w_nxt_state = S_R0;   w_nxt_cnt = '0; end
                S_R0:        begin w_nxt_state = S_DLC;  w_nxt_cnt = '0; end
                S_DLC: begin
                    if (r_cnt == 6'd3) begin
                        w_nxt_state = (w_len_bits == 7'd0) ? S_CRC : S_DATA;
                        w_nxt_cnt   = '0;
                    end
                end
                S_DATA: begin
                    if (r_cnt == w_data_last) begin
                        w_nxt_state = S_CRC;
                        w_nxt_cnt   = '0;
                    end
                end
                S_CRC: begin
                    if (r_cnt == 6'd14) begin
                        w_nxt_state = S_CRC_DELIM;
                        w_nxt_cnt   = '0;
                    end
                end
                S_CRC_DELIM: begin w_nxt_state = S_ACK_SLOT;  w_nxt_cnt = '0; end
                S_ACK_SLOT:  begin w_nxt_state = S_ACK_DELIM; w_nxt_cnt = '0; end
                S_ACK_DELIM: begin w_nxt_state = S_EOF;       w_nxt_cnt = '0; end
                S_EOF: begin
                    if (r_cnt == LP_EOF_LAST) begin
                        w_nxt_state = S_IFS;
                        w_nxt_cnt   = '0;
                    end
                end
                S_IFS: begin
                    if (r_cnt == LP_IFS_LAST) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_cnt   = '0;
                        w_done      = 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Unstuffed value of the bit at the next position.
    always_comb begin
        w_field_bit = 1'b1;
        case (w_nxt_state)
            S_SOF:  w_field_bit = 1'b0;
            S_ID_A: w_field_bit = r_id_a[4'd10 - w_nxt_cnt[3:0]];
            S_SRR:  w_field_bit = 1'b1;
            S_IDE:  w_field_bit = r_ide;
            S_ID_B: w_field_bit = r_id_b[5'd17 - w_nxt_cnt[4:0]];
            S_RTR:  w_field_bit = r_rtr;
            S_R1:   w_field_bit = 1'b0;
            S_R0:   w_field_bit = 1'b0;
            S_DLC:  w_field_bit = r_dlc[2'd3 - w_nxt_cnt[1:0]];
            S_DATA: w_field_bit = r_data[6'd63 - w_nxt_cnt];
            S_CRC:  w_field_bit = r_crc[4'd14 - w_nxt_cnt[3:0]];
            default: w_field_bit = 1'b1;
        endcase
    end

    // Edge detect, frame latch, serial output, CRC, stuff run and pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp_q    <= 1'b0;
            r_tx_bit  <= 1'b1;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_crc     <= '0;
            r_run     <= '0;
            r_id_a    <= '0;
            r_ide     <= 1'b0;
            r_rtr     <= 1'b0;
            r_id_b    <= '0;
            r_dlc     <= '0;
            r_data    <= '0;
        end else begin
            r_sp_q    <= sample_point;
            r_done    <= w_done;
            r_ack_err <= w_sample_tick && (r_state == S_ACK_SLOT) && rx_bit;
            if (r_state == S_IDLE && tx_start) begin
                r_id_a <= field_id_a;
                r_ide  <= field_ide;
                r_rtr  <= field_rtr;
                r_id_b <= field_id_b;
                r_dlc  <= field_dlc;
                r_data <= field_data;
                r_crc  <= '0;
                r_run  <= '0;
            end else if (w_drive_tick && r_state != S_IDLE) begin
                if (w_stuff) begin
                    r_tx_bit <= ~r_tx_bit;
                    r_run    <= 4'd1;
                end else begin
                    r_tx_bit <= w_field_bit;
                    r_run    <= (w_field_bit == r_tx_bit) ? r_run + 4'd1 : 4'd1;
                    if (w_nxt_state >= S_SOF && w_nxt_state <= S_DATA)
                        r_crc <= w_crc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_encoder.sv
// tb_can_encoder: directed frames for can_encoder. Every tx_bit seen on a
// rising sample_point while busy is captured and compared against a bit
// stream built independently from the frame fields.
module tb_can_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_point;
    logic        rx_bit;
    logic        tx_start;
    logic [10:0] field_id_a;
    logic        field_ide;
    logic        field_rtr;
    logic [17:0] field_id_b;
    logic [3:0]  field_dlc;
    logic [63:0] field_data;
    logic        tx_bit;
    logic        tx_busy;
    logic        tx_done;
    logic        ack_error;
    logic [14:0] field_crc;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int ack_cnt  = 0;

    logic        cap[$];
    logic        exp_q[$];
    logic [14:0] exp_crc;

    can_encoder #(.STUFF_LEN(5), .IFS_BITS(3), .EOF_BITS(7)) dut (
        .clock(clock), .reset(reset), .sample_point(sample_point),
        .rx_bit(rx_bit), .tx_start(tx_start), .field_id_a(field_id_a),
        .field_ide(field_ide), .field_rtr(field_rtr), .field_id_b(field_id_b),
        .field_dlc(field_dlc), .field_data(field_data), .tx_bit(tx_bit),
        .tx_busy(tx_busy), .tx_done(tx_done), .ack_error(ack_error),
        .field_crc(field_crc)
    );

    always #5 clock = ~clock;

    // Bit time of 8 clocks, toggled away from the active edge.
    initial begin
        sample_point = 1'b0;
        forever begin
            repeat (4) @(negedge clock);
            sample_point = ~sample_point;
        end
    end

    always @(posedge sample_point) if (tx_busy === 1'b1) cap.push_back(tx_bit);

    always @(negedge clock) begin
        if (tx_done === 1'b1)   done_cnt <= done_cnt + 1;
        if (ack_error === 1'b1) ack_cnt  <= ack_cnt + 1;
    end

    function automatic logic capbit(input int idx);
        return (idx < cap.size()) ? cap[idx] : 1'bx;
    endfunction

    // Reference frame: unstuffed fields, CRC-15, stuffing, trailer of 13 ones.
    task automatic build_expected(input logic ide, input logic rtr,
                                  input logic [10:0] ida, input logic [17:0] idb,
                                  input logic [3:0] dlc, input logic [63:0] data);
        logic        u[$];
        logic [14:0] c;
        logic        nb;
        logic        last;
        int          nbytes;
        int          run;
        u = {};
        u.push_back(1'b0);
        for (int i = 10; i >= 0; i--) u.push_back(ida[i]);
        if (ide) begin
            u.push_back(1'b1);
            u.push_back(1'b1);
            for (int i = 17; i >= 0; i--) u.push_back(idb[i]);
            u.push_back(rtr);
            u.push_back(1'b0);
            u.push_back(1'b0);
        end else begin
            u.push_back(rtr);
            u.push_back(1'b0);
            u.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nbytes * 8; i++) u.push_back(data[63 - i]);
        c = '0;
        foreach (u[k]) begin
            nb = u[k] ^ c[14];
            c  = {c[13:0], 1'b0} ^ (nb ? 15'h4599 : 15'h0000);
        end
        exp_crc = c;
        for (int i = 14; i >= 0; i--) u.push_back(c[i]);
        exp_q = {};
        run   = 0;
        last  = 1'b1;
        foreach (u[k]) begin
            exp_q.push_back(u[k]);
            if (u[k] == last) run++; else run = 1;
            last = u[k];
            if (run == 5) begin
                exp_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        repeat (13) exp_q.push_back(1'b1);
    endtask

    // Launch one frame just after a sample tick and wait for tx_done.
    task automatic send_frame(input logic ide, input logic rtr,
                              input logic [10:0] ida, input logic [17:0] idb,
                              input logic [3:0] dlc, input logic [63:0] data,
                              input logic rxv, input logic poke,
                              output int start_idx, output logic timeout);
        int d0;
        field_ide  = ide;
        field_rtr  = rtr;
        field_id_a = ida;
        field_id_b = idb;
        field_dlc  = dlc;
        field_data = data;
        rx_bit     = rxv;
        @(posedge sample_point);
        @(negedge clock);
        tx_start = 1'b1;
        @(negedge clock);
        tx_start  = 1'b0;
        start_idx = cap.size();
        d0        = done_cnt;
        if (poke) begin
            repeat (80) @(negedge clock);
            field_id_a = ~ida;
            field_ide  = ~ide;
            field_dlc  = 4'd2;
            field_data = ~data;
            tx_start   = 1'b1;
            @(negedge clock);
            tx_start   = 1'b0;
        end
        timeout = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (done_cnt != d0) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; tx_start = 1'b0; rx_bit = 1'b0;
        field_id_a = '0; field_ide = 1'b0; field_rtr = 1'b0;
        field_id_b = '0; field_dlc = '0; field_data = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++; if (tx_bit !== 1'b1) begin bad++; $display("FAIL reset_tx_bit: got %b want 1", tx_bit); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
        total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack_error); end
        total++; if (field_crc !== 15'h0) begin bad++; $display("FAIL reset_crc: got %h want 0", field_crc); end
    endtask

    // T1: all-zero standard frame, stuff 1 after each run of five zeros.
    task automatic test_std_zero;
        int s, d0, nerr, len;
        logic to;
        logic [11:0] head;
        d0 = done_cnt;
        build_expected(1'b0, 1'b0, 11'h0, 18'h0, 4'd0, 64'h0);
        send_frame(1'b0, 1'b0, 11'h0, 18'h0, 4'd0, 64'h0, 1'b0, 1'b0, s, to);
        repeat (40) @(negedge clock);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL t1_timeout: no tx_done within budget"); end
        for (int k = 0; k < 12; k++) head[11 - k] = capbit(s + k);
        total++; if (head !== 12'b000001000001) begin bad++; $display("FAIL t1_head: got %b want 000001000001", head); end
        len = cap.size() - s;
        total++; if (len !== 53) begin bad++; $display("FAIL t1_len: got %0d want 53", len); end
        total++; if (field_crc !== 15'h0000) begin bad++; $display("FAIL t1_crc: got %h want 0000", field_crc); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL t1_done: got %0d pulses want 1", done_cnt - d0); end
        nerr = 0;
        for (int k = 0; k < exp_q.size(); k++) if (capbit(s + k) !== exp_q[k]) nerr++;
        total++; if (nerr != 0 || len != exp_q.size()) begin bad++; $display("FAIL t1_stream: %0d bit errors, len %0d want %0d", nerr, len, exp_q.size()); end
    endtask

    // T2: one data byte, ACK given; optionally with tx_start poked while busy.
    task automatic test_std_data(input logic poke);
        int s, d0, a0, nerr, len;
        logic to;
        d0 = done_cnt; a0 = ack_cnt;
        build_expected(1'b0, 1'b0, 11'h123, 18'h0, 4'd1, 64'hAA00_0000_0000_0000);
        send_frame(1'b0, 1'b0, 11'h123, 18'h0, 4'd1, 64'hAA00_0000_0000_0000, 1'b0, poke, s, to);
        repeat (40) @(negedge clock);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL t2_timeout poke=%b: no tx_done", poke); end
        total++; if (field_crc !== exp_crc) begin bad++; $display("FAIL t2_crc poke=%b: got %h want %h", poke, field_crc, exp_crc); end
        total++; if (ack_cnt - a0 !== 0) begin bad++; $display("FAIL t2_ack poke=%b: got %0d pulses want 0", poke, ack_cnt - a0); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL t2_done poke=%b: got %0d pulses want 1", poke, done_cnt - d0); end
        len = cap.size() - s; nerr = 0;
        for (int k = 0; k < exp_q.size(); k++) if (capbit(s + k) !== exp_q[k]) nerr++;
        total++; if (nerr != 0 || len != exp_q.size()) begin bad++; $display("FAIL t2_stream poke=%b: %0d bit errors, len %0d want %0d", poke, nerr, len, exp_q.size()); end
    endtask

    // T3: extended all-ones frame, stuff 0 after each run of five ones.
    task automatic test_ext_ones;
        int s, nerr, len;
        logic to;
        logic [5:0] head;
        build_expected(1'b1, 1'b0, 11'h7FF, 18'h3FFFF, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        send_frame(1'b1, 1'b0, 11'h7FF, 18'h3FFFF, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, s, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL t3_timeout: no tx_done"); end
        for (int k = 0; k < 6; k++) head[5 - k] = capbit(s + 1 + k);
        total++; if (head !== 6'b111110) begin bad++; $display("FAIL t3_stuff0: got %b want 111110", head); end
        total++; if (field_crc !== exp_crc) begin bad++; $display("FAIL t3_crc: got %h want %h", field_crc, exp_crc); end
        len = cap.size() - s; nerr = 0;
        for (int k = 0; k < exp_q.size(); k++) if (capbit(s + k) !== exp_q[k]) nerr++;
        total++; if (nerr != 0 || len != exp_q.size()) begin bad++; $display("FAIL t3_stream: %0d bit errors, len %0d want %0d", nerr, len, exp_q.size()); end
    endtask

    // T4: remote frame with dlc=4; no data, CRC follows the DLC field.
    task automatic test_rtr;
        int s, nerr, len;
        logic to;
        logic [3:0] dlcb;
        build_expected(1'b0, 1'b1, 11'h2AA, 18'h0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        send_frame(1'b0, 1'b1, 11'h2AA, 18'h0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, s, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL t4_timeout: no tx_done"); end
        total++; if (capbit(s + 12) !== 1'b1) begin bad++; $display("FAIL t4_rtr_bit: got %b want 1", capbit(s + 12)); end
        for (int k = 0; k < 4; k++) dlcb[3 - k] = capbit(s + 15 + k);
        total++; if (dlcb !== 4'b0100) begin bad++; $display("FAIL t4_dlc: got %b want 0100", dlcb); end
        total++; if (capbit(s + 19) !== exp_crc[14]) begin bad++; $display("FAIL t4_crc_start: got %b want %b", capbit(s + 19), exp_crc[14]); end
        len = cap.size() - s; nerr = 0;
        for (int k = 0; k < exp_q.size(); k++) if (capbit(s + k) !== exp_q[k]) nerr++;
        total++; if (nerr != 0 || len != exp_q.size()) begin bad++; $display("FAIL t4_stream: %0d bit errors, len %0d want %0d", nerr, len, exp_q.size()); end
    endtask

    // T5: no ACK from the bus; one ack_error pulse, frame still completes.
    task automatic test_ack_error;
        int s, d0, a0, nerr, len;
        logic to;
        d0 = done_cnt; a0 = ack_cnt;
        build_expected(1'b0, 1'b0, 11'h055, 18'h0, 4'd2, 64'h5A3C_0000_0000_0000);
        send_frame(1'b0, 1'b0, 11'h055, 18'h0, 4'd2, 64'h5A3C_0000_0000_0000, 1'b1, 1'b0, s, to);
        repeat (40) @(negedge clock);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL t5_timeout: no tx_done"); end
        total++; if (ack_cnt - a0 !== 1) begin bad++; $display("FAIL t5_ack: got %0d pulses want 1", ack_cnt - a0); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL t5_done: got %0d pulses want 1", done_cnt - d0); end
        len = cap.size() - s; nerr = 0;
        for (int k = 0; k < exp_q.size(); k++) if (capbit(s + k) !== exp_q[k]) nerr++;
        total++; if (nerr != 0 || len != exp_q.size()) begin bad++; $display("FAIL t5_stream: %0d bit errors, len %0d want %0d", nerr, len, exp_q.size()); end
        rx_bit = 1'b0;
    endtask

    // T6: reset during ID_A aborts the frame; the next frame is clean.
    task automatic test_reset_mid;
        int s, d0, nerr, len;
        logic to, reached;
        field_ide = 1'b0; field_rtr = 1'b0; field_id_a = 11'h0;
        field_id_b = '0; field_dlc = 4'd0; field_data = '0;
        @(posedge sample_point);
        @(negedge clock);
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        s = cap.size(); d0 = done_cnt; reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (cap.size() >= s + 4) begin reached = 1'b1; break; end
        end
        total++; if (reached !== 1'b1) begin bad++; $display("FAIL t6_reach_id: only %0d bits seen", cap.size() - s); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (tx_bit !== 1'b1) begin bad++; $display("FAIL t6_tx_bit: got %b want 1", tx_bit); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL t6_busy: got %b want 0", tx_busy); end
        reset = 1'b0;
        repeat (300) @(negedge clock);
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL t6_no_done: got %0d pulses want 0", done_cnt - d0); end
        build_expected(1'b0, 1'b0, 11'h3C5, 18'h0, 4'd3, 64'h0123_4500_0000_0000);
        send_frame(1'b0, 1'b0, 11'h3C5, 18'h0, 4'd3, 64'h0123_4500_0000_0000, 1'b0, 1'b0, s, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL t6_timeout: no tx_done after restart"); end
        len = cap.size() - s; nerr = 0;
        for (int k = 0; k < exp_q.size(); k++) if (capbit(s + k) !== exp_q[k]) nerr++;
        total++; if (nerr != 0 || len != exp_q.size()) begin bad++; $display("FAIL t6_stream: %0d bit errors, len %0d want %0d", nerr, len, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_std_zero();
        test_std_data(1'b0);
        test_std_data(1'b1);
        test_ext_ones();
        test_rtr();
        test_ack_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
